// File: rtl/byte_pkg.sv
// Shared byte-stream types for the byte serializer and its consumers.
package byte_pkg;
  localparam int BYTE_W = 8;
  typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/byte_serializer_if.sv
// Word-in / byte-out valid-ready bundle; master is the upstream producer plus downstream consumer side.
interface byte_serializer_if #(
  parameter int unsigned WORD_BYTES = 4
);
  import byte_pkg::*;

  logic [8*WORD_BYTES-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  byte_t                   out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/byte_serializer.sv
// Splits one WORD_BYTES-wide word per handshake into LSB-first bytes with a last flag.
module byte_serializer #(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  byte_serializer_if.slave  bus
);
  import byte_pkg::*;

  localparam int unsigned       IDX_W    = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_BYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                            r_state, w_state_nxt;
  logic [IDX_W-1:0]                  r_idx, w_idx_nxt;
  logic [WORD_BYTES-1:0][BYTE_W-1:0] r_hold, w_hold_nxt;
  logic                              w_last;

  // State, byte index and word hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Next state and handshake outputs; in_ready reopens on the final byte's fire for gapless words.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_hold_nxt    = r_hold;
    w_last        = (r_idx == LAST_IDX);
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;

    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_hold_nxt  = bus.in_data;
          w_idx_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_hold[r_idx];
        bus.out_last  = w_last;
        if (bus.out_ready) begin
          if (!w_last) begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end else begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
              w_hold_nxt = bus.in_data;
              w_idx_nxt  = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_byte_serializer.sv
// Directed vector bench for byte_serializer at WORD_BYTES=4 and WORD_BYTES=2.
module tb_byte_serializer;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  byte_serializer_if #(.WORD_BYTES(4)) bus4 ();
  byte_serializer_if #(.WORD_BYTES(2)) bus2 ();

  byte_serializer #(.WORD_BYTES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  byte_serializer #(.WORD_BYTES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [7:0]  exp_out_data;
    logic        exp_out_last;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [31:0] d, input logic v, input logic rdy,
                     input logic eir, input logic eov, input logic [7:0] eod, input logic eol);
    vec_t t;
    t.rst = r; t.in_data = d; t.in_valid = v; t.out_ready = rdy;
    t.exp_in_ready = eir; t.exp_out_valid = eov; t.exp_out_data = eod; t.exp_out_last = eol;
    vecs.push_back(t);
  endtask

  task automatic check4(input string tag, input logic eir, input logic eov,
                        input logic [7:0] eod, input logic eol);
    chk({tag, ".in_ready"},  32'(bus4.in_ready),  32'(eir));
    chk({tag, ".out_valid"}, 32'(bus4.out_valid), 32'(eov));
    chk({tag, ".out_data"},  32'(bus4.out_data),  32'(eod));
    chk({tag, ".out_last"},  32'(bus4.out_last),  32'(eol));
  endtask

  task automatic check2(input string tag, input logic eir, input logic eov,
                        input logic [7:0] eod, input logic eol);
    chk({tag, ".in_ready"},  32'(bus2.in_ready),  32'(eir));
    chk({tag, ".out_valid"}, 32'(bus2.out_valid), 32'(eov));
    chk({tag, ".out_data"},  32'(bus2.out_data),  32'(eod));
    chk({tag, ".out_last"},  32'(bus2.out_last),  32'(eol));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus4.in_data   = '0;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    bus2.in_data   = '0;
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b0;

    // rst data v rdy | in_ready out_valid out_data out_last
    // 1: single word, out_ready held high
    add(0, 32'h0,        0, 1,  1, 0, 8'h00, 0);
    add(0, 32'hDDCCBBAA, 1, 1,  1, 0, 8'h00, 0);
    add(0, 32'h0,        0, 1,  0, 1, 8'hAA, 0);
    add(0, 32'h0,        0, 1,  0, 1, 8'hBB, 0);
    add(0, 32'h0,        0, 1,  0, 1, 8'hCC, 0);
    add(0, 32'h0,        0, 1,  1, 1, 8'hDD, 1);
    add(0, 32'h0,        0, 1,  1, 0, 8'h00, 0);
    // 2: out_ready toggling, bytes held while stalled
    add(0, 32'hDDCCBBAA, 1, 0,  1, 0, 8'h00, 0);
    add(0, 32'h0,        0, 1,  0, 1, 8'hAA, 0);
    add(0, 32'h0,        0, 0,  0, 1, 8'hBB, 0);
    add(0, 32'h0,        0, 1,  0, 1, 8'hBB, 0);
    add(0, 32'h0,        0, 0,  0, 1, 8'hCC, 0);
    add(0, 32'h0,        0, 1,  0, 1, 8'hCC, 0);
    add(0, 32'h0,        0, 0,  0, 1, 8'hDD, 1);
    add(0, 32'h0,        0, 1,  1, 1, 8'hDD, 1);
    add(0, 32'h0,        0, 1,  1, 0, 8'h00, 0);
    // 3: back-to-back words; second word waits with in_valid high
    add(0, 32'h44332211, 1, 1,  1, 0, 8'h00, 0);
    add(0, 32'h88776655, 1, 1,  0, 1, 8'h11, 0);
    add(0, 32'h88776655, 1, 1,  0, 1, 8'h22, 0);
    add(0, 32'h88776655, 1, 1,  0, 1, 8'h33, 0);
    add(0, 32'h88776655, 1, 1,  1, 1, 8'h44, 1);
    add(0, 32'h0,        0, 1,  0, 1, 8'h55, 0);
    add(0, 32'h0,        0, 1,  0, 1, 8'h66, 0);
    add(0, 32'h0,        0, 1,  0, 1, 8'h77, 0);
    add(0, 32'h0,        0, 1,  1, 1, 8'h88, 1);
    add(0, 32'h0,        0, 1,  1, 0, 8'h00, 0);
    // 4: reset while CC pending, then a fresh word
    add(0, 32'hDDCCBBAA, 1, 1,  1, 0, 8'h00, 0);
    add(0, 32'h0,        0, 1,  0, 1, 8'hAA, 0);
    add(0, 32'h0,        0, 1,  0, 1, 8'hBB, 0);
    add(1, 32'h0,        0, 0,  0, 1, 8'hCC, 0);
    add(0, 32'h0,        0, 1,  1, 0, 8'h00, 0);
    add(0, 32'h000000EE, 1, 1,  1, 0, 8'h00, 0);
    add(0, 32'h0,        0, 1,  0, 1, 8'hEE, 0);
    add(0, 32'h0,        0, 1,  0, 1, 8'h00, 0);
    add(0, 32'h0,        0, 1,  0, 1, 8'h00, 0);
    add(0, 32'h0,        0, 1,  1, 1, 8'h00, 1);
    add(0, 32'h0,        0, 1,  1, 0, 8'h00, 0);

    do_reset();
    foreach (vecs[i]) begin
      rst            = vecs[i].rst;
      bus4.in_data   = vecs[i].in_data;
      bus4.in_valid  = vecs[i].in_valid;
      bus4.out_ready = vecs[i].out_ready;
      #1;
      check4($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_out_valid,
             vecs[i].exp_out_data, vecs[i].exp_out_last);
      next_cycle();
    end
    rst = 1'b0;

    // 5: upstream idle for 10 cycles after reset, in_data noise must be ignored
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus4.in_valid  = 1'b0;
      bus4.in_data   = 32'hFFFF_FFFF ^ 32'(c);
      bus4.out_ready = c[0];
      #1;
      check4($sformatf("idle%0d", c), 1'b1, 1'b0, 8'h00, 1'b0);
      next_cycle();
    end

    // 6: WORD_BYTES=2, with a stall on the last byte
    bus2.in_data   = 16'hBEEF;
    bus2.in_valid  = 1'b1;
    bus2.out_ready = 1'b1;
    #1;
    check2("w2.accept", 1'b1, 1'b0, 8'h00, 1'b0);
    next_cycle();
    bus2.in_valid  = 1'b0;
    bus2.in_data   = 16'h0;
    #1;
    check2("w2.b0", 1'b0, 1'b1, 8'hEF, 1'b0);
    next_cycle();
    bus2.out_ready = 1'b0;
    #1;
    check2("w2.b1_stall", 1'b0, 1'b1, 8'hBE, 1'b1);
    next_cycle();
    bus2.out_ready = 1'b1;
    #1;
    check2("w2.b1", 1'b1, 1'b1, 8'hBE, 1'b1);
    next_cycle();
    #1;
    check2("w2.idle", 1'b1, 1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
